// File: rtl/i2c_param_regfile_pkg.sv
// Shared types and helpers for the I2C parameter register file:
// FSM state encoding, ACK/NACK bit values and the register-pointer wrap.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEVADDR,
    ACK_DEV,
    REGADDR,
    ACK_REG,
    WDATA,
    ACK_W,
    RDATA,
    RACK
  } state_e;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  // Advance the register pointer, wrapping from the last register back to 0.
  function automatic logic [7:0] ptr_next(input logic [7:0] ptr, input int numRegs);
    if (int'(ptr) >= numRegs - 1) begin
      return 8'd0;
    end
    return ptr + 8'd1;
  endfunction

endpackage

// File: rtl/i2c_param_regfile_if.sv
// I2C pad-side bundle: asynchronous SCL/SDA inputs and the open-drain SDA pull-down enable.
interface i2c_param_regfile_if;
  logic scl_in;
  logic sda_in;
  logic sda_oe;

  modport master (output scl_in, output sda_in, input sda_oe);
  modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_param_regfile_bus_sync.sv
// Two-flop synchronisers for SCL/SDA plus edge, START and STOP detection
// on the synchronised values.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  // Bit 0 is the metastability flop, bit 1 the synchronised value, bit 2 its previous value.
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_in};
      sda_q <= {sda_q[1:0], sda_in};
    end
  end

  assign scl_rise  =  scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] &  scl_q[2];
  assign start_det =  scl_q[1] &  scl_q[2] & ~sda_q[1] &  sda_q[2];
  assign stop_det  =  scl_q[1] &  scl_q[2] &  sda_q[1] & ~sda_q[2];
  assign sda_s     =  sda_q[1];

endmodule

// File: rtl/i2c_param_regfile.sv
// I2C target exposing NUM_REGS parameter registers of DATA_W bits, with
// auto-incrementing burst writes/reads, repeated START and range-checked addressing.
module i2c_param_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h42,
  parameter int         NUM_REGS = 3,
  parameter int         DATA_W   = 6,
  parameter int         RST_VAL  = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  i2c_param_regfile_if.slave         bus,
  output logic [NUM_REGS*DATA_W-1:0] regs,
  output logic                       wr_strobe,
  output logic [7:0]                 wr_index,
  output logic                       busy
);

  localparam logic [DATA_W-1:0] RstV = DATA_W'(RST_VAL);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (bus.scl_in),
    .sda_in    (bus.sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  state_e            state_q;
  logic [3:0]        bitCnt_q;
  logic [7:0]        shift_q;
  logic [7:0]        ptr_q;
  logic              rw_q;
  logic              sdaOe_q;
  logic              busy_q;
  logic              wrStrobe_q;
  logic [7:0]        wrIndex_q;
  logic [DATA_W-1:0] regs_q [NUM_REGS];

  logic [7:0] shiftIn_d;
  logic [7:0] rdByte_d;

  assign shiftIn_d = {shift_q[6:0], sda_s};

  // Zero-extended copy of the register addressed by the pointer, for read-out.
  always_comb begin
    rdByte_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i == int'(ptr_q)) begin
        rdByte_d[DATA_W-1:0] = regs_q[i];
      end
    end
  end

  // START/STOP outrank any SCL edge seen in the same cycle, so a partial byte is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      sdaOe_q    <= 1'b0;
      busy_q     <= 1'b0;
      wrStrobe_q <= 1'b0;
      wrIndex_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RstV;
      end
    end else begin
      wrStrobe_q <= 1'b0;
      if (!ena) begin
        state_q <= IDLE;
        sdaOe_q <= 1'b0;
        busy_q  <= 1'b0;
      end else if (start_det) begin
        state_q  <= DEVADDR;
        bitCnt_q <= '0;
        sdaOe_q  <= 1'b0;
      end else if (stop_det) begin
        state_q <= IDLE;
        sdaOe_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
          end
          DEVADDR: begin
            if (scl_rise && bitCnt_q < 4'd8) begin
              shift_q  <= shiftIn_d;
              bitCnt_q <= bitCnt_q + 4'd1;
              if (bitCnt_q == 4'd7) begin
                if (shiftIn_d[7:1] == DEV_ADDR) begin
                  rw_q   <= shiftIn_d[0];
                  busy_q <= 1'b1;
                end else begin
                  state_q <= IDLE;
                end
              end
            end else if (scl_fall && bitCnt_q == 4'd8) begin
              state_q <= ACK_DEV;
              sdaOe_q <= ~ACK;
            end
          end
          ACK_DEV: begin
            if (scl_fall) begin
              bitCnt_q <= '0;
              if (rw_q) begin
                state_q  <= RDATA;
                shift_q  <= {rdByte_d[6:0], 1'b0};
                sdaOe_q  <= ~rdByte_d[7];
                bitCnt_q <= 4'd1;
              end else begin
                state_q <= REGADDR;
                sdaOe_q <= 1'b0;
              end
            end
          end
          REGADDR: begin
            if (scl_rise && bitCnt_q < 4'd8) begin
              shift_q  <= shiftIn_d;
              bitCnt_q <= bitCnt_q + 4'd1;
              if (bitCnt_q == 4'd7) begin
                if (int'(shiftIn_d) < NUM_REGS) begin
                  ptr_q <= shiftIn_d;
                end else begin
                  state_q <= IDLE;
                end
              end
            end else if (scl_fall && bitCnt_q == 4'd8) begin
              state_q <= ACK_REG;
              sdaOe_q <= ~ACK;
            end
          end
          ACK_REG: begin
            if (scl_fall) begin
              state_q  <= WDATA;
              sdaOe_q  <= 1'b0;
              bitCnt_q <= '0;
            end
          end
          WDATA: begin
            if (scl_rise && bitCnt_q < 4'd8) begin
              shift_q  <= shiftIn_d;
              bitCnt_q <= bitCnt_q + 4'd1;
              if (bitCnt_q == 4'd7) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                  if (i == int'(ptr_q)) begin
                    regs_q[i] <= shiftIn_d[DATA_W-1:0];
                  end
                end
                wrStrobe_q <= 1'b1;
                wrIndex_q  <= ptr_q;
              end
            end else if (scl_fall && bitCnt_q == 4'd8) begin
              state_q <= ACK_W;
              sdaOe_q <= ~ACK;
            end
          end
          ACK_W: begin
            if (scl_fall) begin
              state_q  <= WDATA;
              sdaOe_q  <= 1'b0;
              bitCnt_q <= '0;
              ptr_q    <= ptr_next(ptr_q, NUM_REGS);
            end
          end
          RDATA: begin
            if (scl_fall) begin
              if (bitCnt_q == 4'd8) begin
                state_q  <= RACK;
                sdaOe_q  <= 1'b0;
                bitCnt_q <= '0;
              end else begin
                sdaOe_q  <= ~shift_q[7];
                shift_q  <= {shift_q[6:0], 1'b0};
                bitCnt_q <= bitCnt_q + 4'd1;
              end
            end
          end
          RACK: begin
            // bitCnt_q marks that the master's ACK has been seen and the pointer advanced.
            if (scl_rise && bitCnt_q == 4'd0) begin
              if (sda_s == NACK) begin
                state_q <= IDLE;
              end else begin
                ptr_q    <= ptr_next(ptr_q, NUM_REGS);
                bitCnt_q <= 4'd1;
              end
            end else if (scl_fall && bitCnt_q == 4'd1) begin
              state_q <= RDATA;
              shift_q <= {rdByte_d[6:0], 1'b0};
              sdaOe_q <= ~rdByte_d[7];
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign bus.sda_oe = sdaOe_q;
  assign wr_strobe  = wrStrobe_q;
  assign wr_index   = wrIndex_q;
  assign busy       = busy_q;

endmodule
